// File: rtl/regfile_checker.sv
// regfile_checker
// Self-check sequencer for the MIPS core. Holds the core in reset and then
// lets it run for a programmed number of cycles. It then freezes the core and
// compares the GPR file against an expected-value ROM, one register per cycle.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   start          pulse; accepted only in IDLE or DONE
//   run_cycles     processor run budget, latched when start is accepted
//   cpu_reset      active-high reset to the processor
//   cpu_run        processor clock enable, high only while running
//   rd_addr        GPR read index
//   rd_data        GPR read data (combinational from rd_addr)
//   exp_addr       expected-ROM index, mirrors rd_addr
//   exp_data       expected value (combinational from exp_addr)
//   busy           sequence in progress
//   done           result valid, held until the next accepted start
//   pass           no mismatches found (valid with done)
//   fail_idx       index of the first mismatch
//   fail_actual    GPR value at the first mismatch
//   fail_expected  expected value at the first mismatch
//   err_count      number of mismatching registers, saturating
//
// state | meaning
// IDLE  | waiting for start, processor held in reset
// RST   | processor held in reset for RST_CYCLES cycles
// RUN   | processor clock enabled for run_cycles cycles
// SCAN  | processor frozen, one register compared per cycle
// DONE  | result valid, processor state left inspectable
module regfile_checker #(
  parameter int WIDTH         = 32,
  parameter int NREGS         = 32,
  parameter int ADDR_W        = 5,
  parameter int FIRST_REG     = 1,
  parameter int CYCLE_W       = 16,
  parameter int RST_CYCLES    = 2,
  parameter int STOP_ON_FIRST = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CYCLE_W-1:0] run_cycles,
  output logic               cpu_reset,
  output logic               cpu_run,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [WIDTH-1:0]   rd_data,
  output logic [ADDR_W-1:0]  exp_addr,
  input  logic [WIDTH-1:0]   exp_data,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ADDR_W-1:0]  fail_idx,
  output logic [WIDTH-1:0]   fail_actual,
  output logic [WIDTH-1:0]   fail_expected,
  output logic [ADDR_W:0]    err_count
);

  localparam int RST_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_RUN,
    S_SCAN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [CYCLE_W-1:0] run_lat;
  logic [CYCLE_W-1:0] cyc_cnt;
  logic [RST_W-1:0]   rst_cnt;
  logic               accept;
  logic               mismatch;
  logic               last_reg;

  assign accept   = start && ((state == S_IDLE) || (state == S_DONE));
  assign mismatch = (rd_data != exp_data);
  assign last_reg = (rd_addr == ADDR_W'(NREGS - 1));
  assign exp_addr = rd_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cpu_reset = 1'b0;
    cpu_run   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    pass      = 1'b0;
    case (state)
      S_IDLE: begin
        cpu_reset = 1'b1;
        if (start) state_nxt = S_RST;
      end
      S_RST: begin
        cpu_reset = 1'b1;
        busy      = 1'b1;
        if (rst_cnt == RST_W'(1)) state_nxt = (run_lat != '0) ? S_RUN : S_SCAN;
      end
      S_RUN: begin
        cpu_run = 1'b1;
        busy    = 1'b1;
        if (cyc_cnt == run_lat - 1'b1) state_nxt = S_SCAN;
      end
      S_SCAN: begin
        busy = 1'b1;
        // Early exit takes effect on the same edge that records the mismatch.
        if (last_reg || ((STOP_ON_FIRST != 0) && mismatch)) state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        pass = (err_count == '0);
        if (start) state_nxt = S_RST;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_lat       <= '0;
      cyc_cnt       <= '0;
      rst_cnt       <= '0;
      rd_addr       <= ADDR_W'(FIRST_REG);
      err_count     <= '0;
      fail_idx      <= '0;
      fail_actual   <= '0;
      fail_expected <= '0;
    end else if (accept) begin
      run_lat       <= run_cycles;
      cyc_cnt       <= '0;
      rst_cnt       <= RST_W'(RST_CYCLES);
      rd_addr       <= ADDR_W'(FIRST_REG);
      err_count     <= '0;
      fail_idx      <= '0;
      fail_actual   <= '0;
      fail_expected <= '0;
    end else begin
      case (state)
        S_RST: rst_cnt <= rst_cnt - 1'b1;
        S_RUN: cyc_cnt <= cyc_cnt + 1'b1;
        S_SCAN: begin
          if (mismatch) begin
            if (err_count == '0) begin
              fail_idx      <= rd_addr;
              fail_actual   <= rd_data;
              fail_expected <= exp_data;
            end
            if (err_count != '1) err_count <= err_count + 1'b1;
          end
          rd_addr <= (state_nxt == S_DONE) ? ADDR_W'(FIRST_REG) : rd_addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_checker.sv
// Bench for regfile_checker: two instances (full scan and stop-on-first)
// share one GPR model and one expected ROM held as plain arrays here.
module tb_regfile_checker;

  localparam int W   = 32;
  localparam int N   = 32;
  localparam int AW  = 5;
  localparam int CW  = 16;
  localparam int RCY = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] run_cycles;

  logic [W-1:0] gpr [N];
  logic [W-1:0] rom [N];

  logic          cpu_reset_a, cpu_run_a, busy_a, done_a, pass_a;
  logic [AW-1:0] rd_addr_a, exp_addr_a, fail_idx_a;
  logic [W-1:0]  rd_data_a, exp_data_a, fail_act_a, fail_exp_a;
  logic [AW:0]   err_a;

  logic          cpu_reset_b, cpu_run_b, busy_b, done_b, pass_b;
  logic [AW-1:0] rd_addr_b, exp_addr_b, fail_idx_b;
  logic [W-1:0]  rd_data_b, exp_data_b, fail_act_b, fail_exp_b;
  logic [AW:0]   err_b;

  assign rd_data_a  = gpr[rd_addr_a];
  assign exp_data_a = rom[exp_addr_a];
  assign rd_data_b  = gpr[rd_addr_b];
  assign exp_data_b = rom[exp_addr_b];

  regfile_checker #(.STOP_ON_FIRST(0)) dut_a (
    .clk(clk), .reset(reset), .start(start), .run_cycles(run_cycles),
    .cpu_reset(cpu_reset_a), .cpu_run(cpu_run_a), .rd_addr(rd_addr_a),
    .rd_data(rd_data_a), .exp_addr(exp_addr_a), .exp_data(exp_data_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail_idx(fail_idx_a),
    .fail_actual(fail_act_a), .fail_expected(fail_exp_a), .err_count(err_a)
  );

  regfile_checker #(.STOP_ON_FIRST(1)) dut_b (
    .clk(clk), .reset(reset), .start(start), .run_cycles(run_cycles),
    .cpu_reset(cpu_reset_b), .cpu_run(cpu_run_b), .rd_addr(rd_addr_b),
    .rd_data(rd_data_b), .exp_addr(exp_addr_b), .exp_data(exp_data_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .fail_idx(fail_idx_b),
    .fail_actual(fail_act_b), .fail_expected(fail_exp_b), .err_count(err_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          rc;
    int          idx1;
    logic [W-1:0] val1;
    int          idx2;
    logic [W-1:0] val2;
    int          exp_err;
    int          exp_fidx;
  } vec_t;

  task automatic load_rom(input logic [W-1:0] v);
    for (int i = 0; i < N; i++) begin
      rom[i] = v;
      gpr[i] = v;
    end
  endtask

  // One check sequence. Latency rule: RST + run + scanned regs + 1; the
  // stop-on-first instance scans only up to the first mismatching index.
  task automatic do_run(input string nm, input int rc, input int inject_at,
                        input int alt, input int exp_err, input int exp_fidx);
    int cyc, lat_a, lat_b, run_cnt, full, stop_lat;
    logic [W-1:0] e_act, e_exp;
    full     = RCY + rc + (N - 1) + 1;
    stop_lat = (exp_err > 0) ? RCY + rc + exp_fidx + 1 : full;
    e_act    = (exp_err > 0) ? gpr[exp_fidx] : '0;
    e_exp    = (exp_err > 0) ? rom[exp_fidx] : '0;
    lat_a = -1; lat_b = -1; run_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    run_cycles = CW'(rc);
    @(posedge clk);
    cyc = 1;
    forever begin
      @(negedge clk);
      start = (cyc == inject_at);
      if (cyc == inject_at) run_cycles = CW'(alt);
      if (cpu_run_a) run_cnt++;
      if (done_a && lat_a < 0) lat_a = cyc;
      if (done_b && lat_b < 0) lat_b = cyc;
      if ((lat_a >= 0 && lat_b >= 0) || cyc >= 2000) break;
      @(posedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({nm, "_lat_full"}, 64'(lat_a), 64'(full));
    chk({nm, "_lat_stop"}, 64'(lat_b), 64'(stop_lat));
    chk({nm, "_run_cycles"}, 64'(run_cnt), 64'(rc));
    chk({nm, "_err"}, 64'(err_a), 64'(exp_err));
    chk({nm, "_pass"}, 64'(pass_a), 64'(exp_err == 0));
    chk({nm, "_fidx"}, 64'(fail_idx_a), 64'(exp_err > 0 ? exp_fidx : 0));
    chk({nm, "_factual"}, 64'(fail_act_a), 64'(e_act));
    chk({nm, "_fexpected"}, 64'(fail_exp_a), 64'(e_exp));
    chk({nm, "_done_outs"}, {61'd0, cpu_reset_a, cpu_run_a, busy_a}, 64'd0);
    chk({nm, "_rd_addr"}, 64'(rd_addr_a), 64'd1);
    chk({nm, "_stop_err"}, 64'(err_b), 64'(exp_err > 0 ? 1 : 0));
    chk({nm, "_stop_fidx"}, 64'(fail_idx_b), 64'(exp_err > 0 ? exp_fidx : 0));
    chk({nm, "_stop_pass"}, 64'(pass_b), 64'(exp_err == 0));
  endtask

  vec_t vecs[6];

  initial begin
    int n_err, f_idx, nm, idx;
    vecs[0] = '{rc: 5, idx1: 0,  val1: 32'hcafebabe, idx2: 0,  val2: 32'hcafebabe, exp_err: 0, exp_fidx: 0};
    vecs[1] = '{rc: 5, idx1: 7,  val1: 32'h0,        idx2: 20, val2: 32'h1,        exp_err: 2, exp_fidx: 7};
    vecs[2] = '{rc: 0, idx1: 0,  val1: 32'hcafebabe, idx2: 0,  val2: 32'hcafebabe, exp_err: 0, exp_fidx: 0};
    vecs[3] = '{rc: 1, idx1: 31, val1: 32'h12345678, idx2: 0,  val2: 32'hcafebabe, exp_err: 1, exp_fidx: 31};
    vecs[4] = '{rc: 3, idx1: 0,  val1: 32'h0,        idx2: 0,  val2: 32'hffffffff, exp_err: 0, exp_fidx: 0};
    vecs[5] = '{rc: 0, idx1: 2,  val1: 32'hdeadbeef, idx2: 1,  val2: 32'h0,        exp_err: 2, exp_fidx: 1};

    reset = 1'b0;
    start = 1'b0;
    run_cycles = '0;
    load_rom(32'hcafebabe);
    #12;
    chk("reset_outs", {58'd0, cpu_reset_a, cpu_run_a, busy_a, done_a, pass_a, 1'b0},
        {58'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("reset_err", 64'(err_a), 64'd0);
    chk("reset_rd_addr", 64'(rd_addr_a), 64'd1);
    @(negedge clk);
    reset = 1'b1;

    for (int v = 0; v < 6; v++) begin
      load_rom(32'hcafebabe);
      gpr[vecs[v].idx1] = vecs[v].val1;
      gpr[vecs[v].idx2] = vecs[v].val2;
      do_run($sformatf("vec%0d", v), vecs[v].rc, -1, 0, vecs[v].exp_err, vecs[v].exp_fidx);
    end

    // start pulsed mid-RUN with a different budget must change nothing
    load_rom(32'hcafebabe);
    gpr[9] = 32'h9;
    do_run("start_in_run", 20, 8, 3, 1, 9);

    // async reset while scanning register 12, with a mismatch already logged
    load_rom(32'hcafebabe);
    gpr[5] = 32'h5;
    @(negedge clk);
    start = 1'b1;
    run_cycles = CW'(2);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy_a && rd_addr_a == AW'(12)) break;
      @(negedge clk);
    end
    chk("reach_scan12", 64'(rd_addr_a), 64'd12);
    chk("scan12_err_before", 64'(err_a), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_outs", {59'd0, cpu_reset_a, cpu_run_a, busy_a, done_a, pass_a},
        {59'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("abort_err", 64'(err_a), 64'd0);
    chk("abort_fail", {27'd0, fail_idx_a, fail_act_a}, 64'd0);
    chk("abort_rd_addr", 64'(rd_addr_a), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    do_run("after_abort", 4, -1, 0, 1, 5);

    // randomized programs checked against a direct count over the arrays
    for (int r = 0; r < 8; r++) begin
      load_rom($urandom());
      for (int i = 0; i < N; i++) rom[i] = $urandom();
      for (int i = 0; i < N; i++) gpr[i] = rom[i];
      nm = $urandom_range(0, 3);
      for (int k = 0; k < nm; k++) begin
        idx = $urandom_range(0, N - 1);
        gpr[idx] = gpr[idx] ^ ($urandom() | 32'h1);
      end
      n_err = 0;
      f_idx = 0;
      for (int i = 1; i < N; i++) begin
        if (gpr[i] != rom[i]) begin
          if (n_err == 0) f_idx = i;
          n_err++;
        end
      end
      do_run($sformatf("rand%0d", r), $urandom_range(0, 40), -1, 0, n_err, f_idx);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
